// File: rtl/cram_pkg.sv
// Shared types and CRC-8 helper for the CRAM bitstream loader.
package cram_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, VERIFY, DONE} cram_ld_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cram_crc8.sv
// Bit-serial CRC-8 accumulator (init 0x00); clr takes priority over bit_en.
module cram_crc8
    import cram_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr)
            crc_d = 8'h00;
        else if (bit_en)
            crc_d = crc8_step(crc_q, bit_in);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) crc_q <= 8'h00;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/cram_loader.sv
// Serialises configuration words MSB-first into the CRAM chain, then rotates the
// chain once and compares a CRC-8 of the readback against the CRC-8 of the load.
module cram_loader
    import cram_pkg::*;
#(
    parameter int CHAIN_LEN = 68,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_en,
    output logic              en,
    output logic              config_data_in,
    input  logic              config_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(WORD_W + 1);

    cram_ld_state_t    state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              pass_q, pass_d;
    logic              crc_clr;
    logic [7:0]        crc_ld, crc_rb;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pass_d  = pass_q;
        crc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    crc_clr = 1'b1;
                end
            end
            FETCH: begin
                if (word_valid) begin
                    sreg_d  = word_in;
                    wcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q + 1'b1;
                wcnt_d = wcnt_q + 1'b1;
                // Chain end wins over word end: a partial last word is dropped here.
                if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = VERIFY;
                end else if (wcnt_q == WCNT_W'(WORD_W - 1)) begin
                    state_d = FETCH;
                end
            end
            VERIFY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    // Fold in the final readback bit now so pass is valid alongside done.
                    pass_d  = (crc8_step(crc_rb, config_data_out) == crc_ld);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pass_q  <= pass_d;
        end
    end

    cram_crc8 u_crc_ld (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (crc_clr),
        .bit_en (state_q == SHIFT),
        .bit_in (sreg_q[WORD_W-1]),
        .crc    (crc_ld)
    );

    cram_crc8 u_crc_rb (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (crc_clr),
        .bit_en (state_q == VERIFY),
        .bit_in (config_data_out),
        .crc    (crc_rb)
    );

    assign word_ready     = (state_q == FETCH);
    assign busy           = (state_q == FETCH) || (state_q == SHIFT) || (state_q == VERIFY);
    assign config_en      = busy;
    assign en             = (state_q == SHIFT) || (state_q == VERIFY);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign config_data_in = (state_q == SHIFT)  ? sreg_q[WORD_W-1] :
                            (state_q == VERIFY) ? config_data_out  : 1'b0;

endmodule

// File: tb/tb_cram_loader.sv
// Directed bench for cram_loader with a 20-bit behavioural chain model.
module tb_cram_loader;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] word_in = 8'h00;
    logic       word_valid = 1'b0;
    logic       word_ready, config_en, en, config_data_in, config_data_out;
    logic       busy, done, pass;

    int n_tests = 0;
    int n_fail  = 0;

    cram_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .start           (start),
        .word_in         (word_in),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .config_en       (config_en),
        .en              (en),
        .config_data_in  (config_data_in),
        .config_data_out (config_data_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass)
    );

    always #5 clk = ~clk;

    // Chain model: shifts on en && config_en; optional single-bit upset on the last load shift.
    logic [19:0] chain = '0;
    logic [19:0] chain_ld = '0;
    logic [19:0] chain_nxt;
    logic        mdl_clr = 1'b0;
    logic        inject = 1'b0;
    int          shift_cnt = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          cfg_cycles = 0;
    int          cfg_err = 0;
    int          en_err = 0;

    assign config_data_out = chain[19];
    assign chain_nxt = {chain[18:0], config_data_in} ^
                       ((inject && shift_cnt == 19) ? 20'h00080 : 20'h00000);

    always @(posedge clk) begin
        if (mdl_clr) begin
            shift_cnt  <= 0;
            hs_cnt     <= 0;
            done_cnt   <= 0;
            cfg_cycles <= 0;
        end else begin
            if (en && config_en) begin
                chain     <= chain_nxt;
                shift_cnt <= shift_cnt + 1;
                if (shift_cnt == 19) chain_ld <= chain_nxt;
            end
            if (word_valid && word_ready) hs_cnt <= hs_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (config_en) cfg_cycles <= cfg_cycles + 1;
        end
    end

    always @(negedge clk) begin
        if (mdl_clr) begin
            cfg_err <= 0;
            en_err  <= 0;
        end else begin
            if (config_en !== busy || (done && config_en)) cfg_err <= cfg_err + 1;
            if (en && word_ready) en_err <= en_err + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " outputs"},
            {25'd0, word_ready, config_en, en, config_data_in, busy, done, pass}, 32'd0);
    endtask

    logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'hF0};

    // Drives one load; returns cycles from start to done, or aborts via reset at shift rst_at.
    task automatic run_load(input int gap, input bit inj, input bit start_mid, input int rst_at,
                            output int cyc, output bit timeout, output logic pass_at1);
        int widx;
        int gapcnt;
        @(negedge clk);
        mdl_clr = 1'b1;
        inject  = inj;
        @(negedge clk);
        mdl_clr    = 1'b0;
        start      = 1'b1;
        word_in    = words[0];
        word_valid = (gap == 0);
        widx    = 0;
        gapcnt  = gap;
        cyc     = 0;
        timeout = 1'b0;
        pass_at1 = 1'bx;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) pass_at1 = pass;
            if (done) break;
            if (cyc > 400) begin
                timeout = 1'b1;
                break;
            end
            if (rst_at != 0 && shift_cnt == rst_at) begin
                nrst = 1'b0;
                #1;
                chk_all_zero("reset mid-shift");
                @(negedge clk);
                chk("no shift in reset", shift_cnt, rst_at);
                nrst = 1'b1;
                break;
            end
            start = start_mid && (shift_cnt == 25);
            if (word_ready && gapcnt > 0) begin
                word_valid = 1'b0;
                gapcnt--;
            end else if (widx < 3) begin
                word_valid = 1'b1;
                word_in    = words[widx];
            end else begin
                word_valid = 1'b0;
            end
            if (word_valid && word_ready) begin
                widx++;
                gapcnt = gap;
            end
        end
        start      = 1'b0;
        word_valid = 1'b0;
    endtask

    typedef struct {
        int          gap;
        bit          inj;
        bit          start_mid;
        logic [19:0] exp_chain;
        logic        exp_pass;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int  cyc;
        bit  to;
        logic p1;

        vecs[0] = '{gap: 0, inj: 1'b0, start_mid: 1'b0, exp_chain: 20'hA53CF, exp_pass: 1'b1, exp_cyc: 44};
        vecs[1] = '{gap: 5, inj: 1'b0, start_mid: 1'b0, exp_chain: 20'hA53CF, exp_pass: 1'b1, exp_cyc: 59};
        vecs[2] = '{gap: 0, inj: 1'b1, start_mid: 1'b0, exp_chain: 20'hA534F, exp_pass: 1'b0, exp_cyc: 44};
        vecs[3] = '{gap: 0, inj: 1'b0, start_mid: 1'b1, exp_chain: 20'hA53CF, exp_pass: 1'b1, exp_cyc: 44};

        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk_all_zero("idle after reset");

        for (int i = 0; i < 4; i++) begin
            run_load(vecs[i].gap, vecs[i].inj, vecs[i].start_mid, 0, cyc, to, p1);
            chk($sformatf("v%0d timeout", i), to, 1'b0);
            chk($sformatf("v%0d cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d pass at done", i), pass, vecs[i].exp_pass);
            if (i > 0) chk($sformatf("v%0d pass cleared", i), p1, 1'b0);
            chk($sformatf("v%0d loaded chain", i), chain_ld, vecs[i].exp_chain);
            // Idle window with word_valid high: must not be accepted.
            word_valid = 1'b1;
            word_in    = 8'h55;
            repeat (5) @(negedge clk);
            word_valid = 1'b0;
            chk($sformatf("v%0d handshakes", i), hs_cnt, 3);
            chk($sformatf("v%0d chain shifts", i), shift_cnt, 40);
            chk($sformatf("v%0d chain after verify", i), chain, vecs[i].exp_chain);
            chk($sformatf("v%0d done pulses", i), done_cnt, 1);
            chk($sformatf("v%0d config_en cycles", i), cfg_cycles, vecs[i].exp_cyc - 1);
            chk($sformatf("v%0d config_en vs busy", i), cfg_err, 0);
            chk($sformatf("v%0d en in fetch", i), en_err, 0);
            chk($sformatf("v%0d pass held", i), pass, vecs[i].exp_pass);
            chk($sformatf("v%0d idle outputs", i), {word_ready, busy, en, config_en}, 4'b0000);
        end

        // Reset during the second word, then a clean reload.
        run_load(0, 1'b0, 1'b0, 12, cyc, to, p1);
        chk("abort timeout", to, 1'b0);
        @(negedge clk);
        chk_all_zero("after abort");
        run_load(0, 1'b0, 1'b0, 0, cyc, to, p1);
        chk("reload timeout", to, 1'b0);
        chk("reload cycles", cyc, 44);
        chk("reload pass", pass, 1'b1);
        chk("reload chain", chain_ld, 20'hA53CF);
        @(negedge clk);
        chk("reload done pulses", done_cnt, 1);
        chk("reload rotated chain", chain, 20'hA53CF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
